// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants and the transmit sequencer state encoding.
package ps2_pkg;

  localparam int IDX_W = 4;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_BSLASH = 8'h5C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAKE,
    ST_F0,
    ST_BRK,
    ST_NEXT,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/ps2_ascii2scan.sv
// ASCII -> Set-2 make code lookup, shared with the receive-side table.
module ps2_ascii2scan
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       valid,
  output logic [7:0] code
);

  always_comb begin
    valid = 1'b1;
    code  = 8'h00;
    case (ascii)
      8'h30:        code = SC_0;
      8'h31:        code = SC_1;
      8'h32:        code = SC_2;
      8'h33:        code = SC_3;
      8'h34:        code = SC_4;
      8'h35:        code = SC_5;
      8'h36:        code = SC_6;
      8'h37:        code = SC_7;
      8'h38:        code = SC_8;
      8'h39:        code = SC_9;
      ASCII_BSLASH: code = SC_ENTER;
      ASCII_SPACE:  code = SC_SPACE;
      default:      valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_tx_sequencer.sv
// Replays a packed ASCII string as PS/2 make/break bytes over a valid/ready link.
//
// state | meaning
// IDLE  | waiting for tx_start
// LOAD  | look up char[idx], decide send or skip
// MAKE  | presenting make code
// F0    | presenting break prefix
// BRK   | presenting make code again (release)
// NEXT  | advance index or finish
// DONE  | tx_done pulse, back to IDLE
module ps2_tx_sequencer
  import ps2_pkg::*;
#(
  parameter int NUM_CHARS  = 13,
  parameter bit BREAK_EN   = 1'b1,
  parameter bit SKIP_SPACE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_start,
  input  logic [8*NUM_CHARS-1:0] tx_register,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   err_unmapped
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  tx_state_t              state;
  logic [IDX_W-1:0]       idx;
  logic [8*NUM_CHARS-1:0] str_q;
  logic [7:0]             code_q;
  logic [7:0]             char_cur;
  logic                   lut_valid;
  logic [7:0]             lut_code;
  logic                   skip_char;
  logic                   xfer;

  // char0 lives in the most significant byte
  always_comb begin
    char_cur = ASCII_SPACE;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (idx == IDX_W'(i)) char_cur = str_q[8*(NUM_CHARS-1-i) +: 8];
    end
  end

  ps2_ascii2scan u_lut (
    .ascii (char_cur),
    .valid (lut_valid),
    .code  (lut_code)
  );

  assign skip_char = !lut_valid || (SKIP_SPACE && (char_cur == ASCII_SPACE));
  assign xfer      = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      str_q        <= {NUM_CHARS{ASCII_SPACE}};
      code_q       <= '0;
      byte_data    <= '0;
      byte_valid   <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            str_q        <= tx_register;
            err_unmapped <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!lut_valid) err_unmapped <= 1'b1;
          if (skip_char) begin
            state <= ST_NEXT;
          end else begin
            code_q     <= lut_code;
            byte_data  <= lut_code;
            byte_valid <= 1'b1;
            state      <= ST_MAKE;
          end
        end
        ST_MAKE: begin
          if (xfer) begin
            if (BREAK_EN) begin
              byte_data <= SC_BREAK;
              state     <= ST_F0;
            end else begin
              byte_valid <= 1'b0;
              state      <= ST_NEXT;
            end
          end
        end
        ST_F0: begin
          if (xfer) begin
            byte_data <= code_q;
            state     <= ST_BRK;
          end
        end
        ST_BRK: begin
          if (xfer) begin
            byte_valid <= 1'b0;
            state      <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (idx == LAST_IDX) begin
            tx_done <= 1'b1;
            state   <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
